// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan receiver: waits for each {anodes,seg} pattern to settle,
// decodes the lit digit back to hex and tracks per-position validity,
// error flags and full-frame completion.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anodes,
  input  logic [6:0]  seg,
  input  logic        clear,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        bad_pattern,
  output logic        multi_anode,
  output logic        frame_done
);

  typedef enum logic [1:0] {SETTLE, CAPTURE, HELD} state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [14:0] samp_q, samp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  seen_q, seen_d;
  logic        bad_q, bad_d;
  logic        multi_q, multi_d;
  logic        frame_q, frame_d;

  logic        same;
  logic        capture;
  logic [2:0]  idx;
  logic [7:0]  mask;
  logic [5:0]  dec;

  // Returns {match, blank, value} for an active-low gfedcba pattern.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b100000;
    case (s)
      7'h40: r[3:0] = 4'h0;
      7'h79: r[3:0] = 4'h1;
      7'h24: r[3:0] = 4'h2;
      7'h30: r[3:0] = 4'h3;
      7'h19: r[3:0] = 4'h4;
      7'h12: r[3:0] = 4'h5;
      7'h02: r[3:0] = 4'h6;
      7'h78: r[3:0] = 4'h7;
      7'h00: r[3:0] = 4'h8;
      7'h10: r[3:0] = 4'h9;
      7'h08: r[3:0] = 4'hA;
      7'h03: r[3:0] = 4'hB;
      7'h46: r[3:0] = 4'hC;
      7'h21: r[3:0] = 4'hD;
      7'h06: r[3:0] = 4'hE;
      7'h0E: r[3:0] = 4'hF;
      7'h7F: r     = 6'b010000;
      default: r   = 6'b000000;
    endcase
    return r;
  endfunction

  // Stability counter and settle/capture/held sequencing.
  always_comb begin
    samp_d  = {anodes, seg};
    cnt_d   = cnt_q;
    state_d = state_q;
    capture = 1'b0;
    same    = ({anodes, seg} == samp_q);
    if (same) begin
      cnt_d = (cnt_q >= STABLE_MAX) ? STABLE_MAX : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    case (state_q)
      SETTLE: begin
        if (same && (cnt_d == STABLE_MAX)) begin
          state_d = CAPTURE;
          capture = 1'b1;
        end
      end
      CAPTURE: state_d = same ? HELD : SETTLE;
      HELD:    state_d = same ? HELD : SETTLE;
      default: state_d = SETTLE;
    endcase
  end

  // Decode a captured sample into digit storage, flags and frame tracking.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    bad_d    = bad_q;
    multi_d  = multi_q;
    frame_d  = 1'b0;
    idx      = 3'd0;
    mask     = seen_q;
    dec      = decode(seg);
    for (int k = 7; k >= 0; k--) begin
      if (!anodes[k]) idx = 3'(k);
    end
    if (capture && !clear && (anodes != 8'hFF)) begin
      if ($countones(~anodes) == 1) begin
        if (dec[5]) begin
          digits_d[{idx, 2'b00} +: 4] = dec[3:0];
          valid_d[idx] = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
          if (!dec[4]) bad_d = 1'b1;
        end
        mask = seen_q | (8'd1 << idx);
        if (mask == 8'hFF) begin
          frame_d = 1'b1;
          seen_d  = 8'h00;
        end else begin
          seen_d  = mask;
        end
      end else begin
        multi_d = 1'b1;
      end
    end
    if (clear) begin
      valid_d = 8'h00;
      seen_d  = 8'h00;
      bad_d   = 1'b0;
      multi_d = 1'b0;
      frame_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SETTLE;
      samp_q   <= '1;
      cnt_q    <= 8'd0;
      digits_q <= 32'h0;
      valid_q  <= 8'h00;
      seen_q   <= 8'h00;
      bad_q    <= 1'b0;
      multi_q  <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      bad_q    <= bad_d;
      multi_q  <= multi_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign bad_pattern = bad_q;
  assign multi_anode = multi_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with STABLE_CYCLES = 4.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  anodes;
  logic [6:0]  seg;
  logic        clear;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        bad_pattern;
  logic        multi_anode;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [8];

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .anodes(anodes),
    .seg(seg),
    .clear(clear),
    .digits(digits),
    .digit_valid(digit_valid),
    .bad_pattern(bad_pattern),
    .multi_anode(multi_anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
    pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;

    reset = 1'b1; anodes = 8'hFF; seg = 7'h7F; clear = 1'b0;
    step(2);
    chk("rst_digits", digits, 32'h0);
    chk("rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("rst_bad", {31'h0, bad_pattern}, 32'h0);
    chk("rst_multi", {31'h0, multi_anode}, 32'h0);
    chk("rst_frame", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;

    // Idle blanking for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_frame", {31'h0, frame_done}, 32'h0);
    end
    chk("idle_digits", digits, 32'h0);
    chk("idle_valid", {24'h0, digit_valid}, 32'h0);
    chk("idle_flags", {30'h0, bad_pattern, multi_anode}, 32'h0);

    // Single digit 2 at position 0.
    anodes = 8'hFE; seg = 7'h24;
    step(3);
    chk("single_early", {24'h0, digit_valid}, 32'h0);
    step(1);
    chk("single_digits", digits, 32'h0000_0002);
    chk("single_valid", {24'h0, digit_valid}, 32'h01);
    step(50);
    chk("hold_digits", digits, 32'h0000_0002);
    chk("hold_valid", {24'h0, digit_valid}, 32'h01);

    // Glitch: 3 on position 1 for 3 edges, then 4 held.
    anodes = 8'hFD; seg = 7'h30;
    step(3);
    chk("glitch_none", digits, 32'h0000_0002);
    seg = 7'h19;
    step(3);
    chk("glitch_early", {24'h0, digit_valid}, 32'h01);
    step(1);
    chk("glitch_digits", digits, 32'h0000_0042);
    chk("glitch_valid", {24'h0, digit_valid}, 32'h03);

    // Full scan 0..7 with 2-edge blanks.
    for (int p = 0; p < 8; p++) begin
      anodes = ~(8'd1 << p); seg = pat[p];
      step(4);
      chk("scan_frame_cap", {31'h0, frame_done}, (p == 7) ? 32'h1 : 32'h0);
      step(1);
      chk("scan_frame_after", {31'h0, frame_done}, 32'h0);
      step(1);
      anodes = 8'hFF; seg = 7'h7F;
      step(2);
      chk("scan_frame_blank", {31'h0, frame_done}, 32'h0);
    end
    chk("scan_digits", digits, 32'h7654_3210);
    chk("scan_valid", {24'h0, digit_valid}, 32'hFF);

    // Undecodable pattern on position 2.
    anodes = 8'hFB; seg = 7'h55;
    step(4);
    chk("bad_flag", {31'h0, bad_pattern}, 32'h1);
    chk("bad_valid", {24'h0, digit_valid}, 32'hFB);
    chk("bad_digits", digits, 32'h7654_3210);

    // Two anodes low.
    anodes = 8'hFC; seg = 7'h40;
    step(4);
    chk("multi_flag", {31'h0, multi_anode}, 32'h1);
    chk("multi_digits", digits, 32'h7654_3210);
    chk("multi_valid", {24'h0, digit_valid}, 32'hFB);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_flags", {30'h0, bad_pattern, multi_anode}, 32'h0);
    chk("clr_valid", {24'h0, digit_valid}, 32'h0);
    chk("clr_digits", digits, 32'h7654_3210);

    // Clear collides with the capture edge of digit 4 at position 3.
    anodes = 8'hF7; seg = 7'h19;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("coll_digits", digits, 32'h7654_3210);
    chk("coll_valid", {24'h0, digit_valid}, 32'h0);
    step(10);
    chk("coll_norecap", digits, 32'h7654_3210);
    chk("coll_norecap_v", {24'h0, digit_valid}, 32'h0);

    // Reset two edges into a settle window for digit 5 at position 4.
    anodes = 8'hEF; seg = 7'h12;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mrst_digits", digits, 32'h0);
    chk("mrst_valid", {24'h0, digit_valid}, 32'h0);
    step(3);
    chk("mrst_nocap", {24'h0, digit_valid}, 32'h0);
    step(1);
    chk("mrst_digits_cap", digits, 32'h0005_0000);
    chk("mrst_valid_cap", {24'h0, digit_valid}, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
